srom_read_arbiter: RTL and testbench

- Round-robin arbiter and access sequencer sharing one 16-bit x 16-entry single-port SROM between NUM_REQ read requesters.
- Drives the SROM's Enable/Read_Enable/Address pins and holds them for the SROM's registered, enable-gated read data.
- Captures that data and returns it to the granted requester with a one-cycle response pulse.
- Sits between client blocks and the SROM instance.

---
 rtl/srom_read_arbiter_if.sv | 47 ++++
 rtl/srom_read_arbiter.sv | 122 ++++++++++++
 tb/tb_srom_read_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/srom_read_arbiter_if.sv
// Bundle of the client-side request/response signals and the SROM pin
// signals handled by srom_read_arbiter.
//   master : the arbiter view (drives responses, Busy and the SROM pins)
//   slave  : the environment view (clients + SROM model)
// Signals:
//   Enable_In            arbiter enable (no new grants when 0)
//   Req_In               per-requester level request
//   Req_Addr_In          flat address bus, slice i belongs to requester i
//   Rsp_Valid_Out        one-cycle response strobe
//   Rsp_Id_Out           index of the requester being answered
//   Rsp_Data_Out         read data returned to the requester
//   Busy_Out             high while an SROM access is in flight
//   Srom_Enable_Out      SROM Enable pin
//   Srom_Read_Enable_Out SROM port-1 read enable pin
//   Srom_Address_Out     SROM port-1 address pin
//   Srom_Read_Data_In    SROM port-1 read data
interface srom_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                          Enable_In;
  logic [NUM_REQ-1:0]            Req_In;
  logic [NUM_REQ*ADDR_WIDTH-1:0] Req_Addr_In;
  logic                          Rsp_Valid_Out;
  logic [ID_W-1:0]               Rsp_Id_Out;
  logic [DATA_WIDTH-1:0]         Rsp_Data_Out;
  logic                          Busy_Out;
  logic                          Srom_Enable_Out;
  logic                          Srom_Read_Enable_Out;
  logic [ADDR_WIDTH-1:0]         Srom_Address_Out;
  logic [DATA_WIDTH-1:0]         Srom_Read_Data_In;

  modport master (
    input  Enable_In, Req_In, Req_Addr_In, Srom_Read_Data_In,
    output Rsp_Valid_Out, Rsp_Id_Out, Rsp_Data_Out, Busy_Out,
           Srom_Enable_Out, Srom_Read_Enable_Out, Srom_Address_Out
  );

  modport slave (
    output Enable_In, Req_In, Req_Addr_In, Srom_Read_Data_In,
    input  Rsp_Valid_Out, Rsp_Id_Out, Rsp_Data_Out, Busy_Out,
           Srom_Enable_Out, Srom_Read_Enable_Out, Srom_Address_Out
  );
endinterface

// File: rtl/srom_read_arbiter.sv
// Round-robin arbiter and access sequencer sharing one single-port SROM
// between NUM_REQ read requesters. A granted access spends one cycle in
// ISSUE (SROM registers the word) and one in CAPTURE (registered word is
// driven and sampled), then answers the requester with a one-cycle pulse.
// Ports:
//   Clk_In     clock, rising edge
//   Reset_N_In asynchronous active-low reset
//   bus        srom_read_arbiter_if.master (requests, responses, SROM pins)
module srom_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                 Clk_In,
  input  logic                 Reset_N_In,
  srom_read_arbiter_if.master  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant_id;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [ID_W-1:0]       win_id;
  logic                  win_found;
  logic                  take_grant;

  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic                  srom_en;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] srom_addr;

  // Round-robin search: rr_ptr is checked first, then upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && bus.Req_In[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign take_grant = (state == IDLE) && bus.Enable_In && win_found;

  // State register
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic; an in-flight access always runs to completion,
  // independent of Enable_In.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take_grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: SROM pins are held identical over ISSUE and CAPTURE so
  // the SROM keeps driving its registered word while we sample it.
  always_comb begin
    srom_en   = 1'b0;
    busy      = 1'b0;
    srom_addr = '0;
    unique case (state)
      ISSUE, CAPTURE: begin
        srom_en   = 1'b1;
        busy      = 1'b1;
        srom_addr = grant_addr;
      end
      default: ;
    endcase
  end

  // Grant latch, response registers and round-robin pointer. Read data is
  // sampled only in CAPTURE, so an undriven SROM bus never reaches
  // Rsp_Data_Out.
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      grant_id   <= '0;
      grant_addr <= '0;
      rr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      rsp_valid <= (state == CAPTURE);
      if (take_grant) begin
        grant_id   <= win_id;
        grant_addr <= bus.Req_Addr_In[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (state == CAPTURE) begin
        rsp_data <= bus.Srom_Read_Data_In;
        rsp_id   <= grant_id;
        rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

  assign bus.Rsp_Valid_Out        = rsp_valid;
  assign bus.Rsp_Id_Out           = rsp_id;
  assign bus.Rsp_Data_Out         = rsp_data;
  assign bus.Busy_Out             = busy;
  assign bus.Srom_Enable_Out      = srom_en;
  assign bus.Srom_Read_Enable_Out = srom_en;
  assign bus.Srom_Address_Out     = srom_addr;
endmodule

// File: tb/tb_srom_read_arbiter.sv
module tb_srom_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int AW      = 4;
  localparam int DW      = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  srom_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  srom_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk_In     (clk),
    .Reset_N_In (rst_n),
    .bus        (bus)
  );

  // Golden SROM contents: distinct word per address.
  function automatic logic [15:0] gold_word(input int a);
    return 16'((a * 16'h1357) ^ 16'hC3A5);
  endfunction

  // SROM model: registers on edges with both enables high, drives only
  // while both stay high; otherwise a garbage pattern stands in for Z.
  logic [15:0] srom_q = 16'h0000;
  always @(posedge clk)
    if (bus.Srom_Enable_Out && bus.Srom_Read_Enable_Out)
      srom_q <= gold_word(int'(bus.Srom_Address_Out));
  assign bus.Srom_Read_Data_In =
    (bus.Srom_Enable_Out && bus.Srom_Read_Enable_Out) ? srom_q : 16'hBAD0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] id;
    logic [3:0] addr;
  } exp_t;
  exp_t sb_q[$];

  function automatic exp_t mk(input logic [1:0] id, input logic [3:0] addr);
    exp_t e;
    e.id   = id;
    e.addr = addr;
    return e;
  endfunction

  // Response monitor / scoreboard consumer.
  int   en_cycles = 0;
  logic prev_vld  = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cycles = 0;
      prev_vld  = 1'b0;
    end else begin
      if (bus.Srom_Enable_Out && bus.Srom_Read_Enable_Out) begin
        en_cycles++;
        if (sb_q.size() > 0) check("srom_addr", 32'(bus.Srom_Address_Out), 32'(sb_q[0].addr));
        else                 check("srom_en_no_request", 32'(bus.Srom_Enable_Out), 32'd0);
      end
      if (bus.Rsp_Valid_Out) begin
        check("rsp_single_cycle", 32'(prev_vld), 32'd0);
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'(bus.Rsp_Valid_Out), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_id", 32'(bus.Rsp_Id_Out), 32'(mon_e.id));
          check("rsp_data", 32'(bus.Rsp_Data_Out), 32'(gold_word(int'(mon_e.addr))));
          check("srom_hold_cycles", 32'(en_cycles), 32'd2);
        end
        en_cycles = 0;
      end
      prev_vld = bus.Rsp_Valid_Out;
    end
  end

  // Waits (bounded) for the next response; lat = negedges waited, -1 on timeout.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.Rsp_Valid_Out) begin
        lat = i;
        return;
      end
    end
  endtask

  // Drives a request set at a negedge with the DUT idle; each requester
  // drops its request once it has been answered. order packs the
  // expected grant sequence, 2 bits per entry.
  task automatic run_txn(input logic [3:0] mask, input logic [15:0] addrs,
                         input logic [7:0] order, input int n);
    int         lat;
    logic [1:0] id;
    bus.Req_Addr_In = addrs;
    bus.Req_In      = mask;
    for (int k = 0; k < n; k++) begin
      id = order[2*k +: 2];
      sb_q.push_back(mk(id, addrs[4*id +: 4]));
    end
    for (int k = 0; k < n; k++) begin
      id = order[2*k +: 2];
      wait_rsp(lat);
      check("txn_latency", 32'(lat), 32'd3);
      if (lat < 0) begin
        sb_q.delete();
        break;
      end
      bus.Req_In[id] = 1'b0;
    end
    bus.Req_In = '0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.Rsp_Valid_Out, bus.Rsp_Id_Out, bus.Rsp_Data_Out, bus.Busy_Out,
                bus.Srom_Enable_Out, bus.Srom_Read_Enable_Out, bus.Srom_Address_Out});
  endfunction

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] addrs;
    logic [7:0]  order;
    int          n;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Pointer evolution: 0 -> 2 -> 0 -> 0 -> 3 -> 1
    vecs[0] = '{mask: 4'b0010, addrs: 16'h0050, order: 8'h01, n: 1};
    vecs[1] = '{mask: 4'b1000, addrs: 16'hF000, order: 8'h03, n: 1};
    vecs[2] = '{mask: 4'b1111, addrs: 16'h3210, order: 8'hE4, n: 4};
    vecs[3] = '{mask: 4'b0100, addrs: 16'h0A00, order: 8'h02, n: 1};
    vecs[4] = '{mask: 4'b1001, addrs: 16'hC007, order: 8'h03, n: 2};

    bus.Enable_In   = 1'b1;
    bus.Req_In      = '0;
    bus.Req_Addr_In = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", all_outs(), 32'd0);
    end

    foreach (vecs[i]) run_txn(vecs[i].mask, vecs[i].addrs, vecs[i].order, vecs[i].n);

    // Pointer to 0, then requester 0 keeps its request across its response.
    run_txn(4'b1000, 16'h1000, 8'h03, 1);
    bus.Req_Addr_In = 16'h8642;
    bus.Req_In      = 4'b1111;
    sb_q.push_back(mk(2'd0, 4'h2));
    sb_q.push_back(mk(2'd1, 4'h4));
    sb_q.push_back(mk(2'd2, 4'h6));
    sb_q.push_back(mk(2'd3, 4'h8));
    sb_q.push_back(mk(2'd0, 4'h2));
    for (int k = 0; k < 5; k++) begin
      wait_rsp(lat);
      check("reraise_latency", 32'(lat), 32'd3);
      if (k >= 1 && k <= 3) bus.Req_In[k] = 1'b0;
      if (k == 4)           bus.Req_In[0] = 1'b0;
    end
    bus.Req_In = '0;

    for (int a = 0; a < 16; a++) run_txn(4'b0001, 16'(a), 8'h00, 1);

    // Enable gating
    bus.Enable_In   = 1'b0;
    bus.Req_Addr_In = 16'h0D00;
    bus.Req_In      = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gated_busy", 32'(bus.Busy_Out), 32'd0);
      check("gated_srom_en", 32'(bus.Srom_Enable_Out), 32'd0);
    end
    sb_q.push_back(mk(2'd2, 4'hD));
    bus.Enable_In = 1'b1;
    wait_rsp(lat);
    check("enable_latency", 32'(lat), 32'd3);
    bus.Req_In = '0;

    // Enable dropped during ISSUE
    bus.Req_Addr_In = 16'h00E0;
    bus.Req_In      = 4'b0010;
    sb_q.push_back(mk(2'd1, 4'hE));
    @(negedge clk);
    check("issue_busy", 32'(bus.Busy_Out), 32'd1);
    bus.Enable_In = 1'b0;
    wait_rsp(lat);
    check("drop_enable_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("disabled_no_grant", 32'(bus.Busy_Out), 32'd0);
    end
    bus.Req_In    = '0;
    bus.Enable_In = 1'b1;

    // Reset during CAPTURE
    @(negedge clk);
    bus.Req_Addr_In = 16'h0009;
    bus.Req_In      = 4'b0001;
    sb_q.push_back(mk(2'd0, 4'h9));
    @(negedge clk);
    @(negedge clk);
    check("capture_busy", 32'(bus.Busy_Out), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("midreset_outputs", all_outs(), 32'd0);
    sb_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midreset_no_rsp", 32'(bus.Rsp_Valid_Out), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(mk(2'd0, 4'h9));
    wait_rsp(lat);
    check("reserve_latency", 32'(lat), 32'd3);
    bus.Req_In = '0;

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
